// File: rtl/stopwatch_pkg.sv
// rtl/stopwatch_pkg.sv - shared digit width, BCD modulus, digit type and load clamp helper
package stopwatch_pkg;

    localparam int DIGIT_W = 4;
    localparam int BCD_MOD = 10;

    typedef logic [DIGIT_W-1:0] digit_t;

    // Out-of-range load digits are pulled down to the largest legal value.
    function automatic digit_t clamp_digit(input digit_t v, input int unsigned m);
        digit_t lim;
        lim = DIGIT_W'(m - 1);
        return (v > lim) ? lim : v;
    endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// rtl/bcd_digit_cell.sv - one combinational modulo-MOD digit with carry/borrow out
module bcd_digit_cell
    import stopwatch_pkg::*;
#(
    parameter int unsigned MOD = BCD_MOD,
    parameter int          DW  = DIGIT_W
) (
    input  logic [DW-1:0] value_i,
    input  logic          inc_i,
    input  logic          dec_i,
    output logic [DW-1:0] next_o,
    output logic          carry_o,
    output logic          borrow_o
);

    localparam logic [DW-1:0] MAX_V = DW'(MOD - 1);

    logic at_max;
    logic at_zero;

    assign at_max   = (value_i == MAX_V);
    assign at_zero  = (value_i == '0);
    assign carry_o  = inc_i & at_max;
    assign borrow_o = dec_i & at_zero;

    // Next digit value: step up or down, rolling over at the modulus edges.
    always_comb begin
        next_o = value_i;
        if (inc_i) begin
            next_o = at_max ? '0 : value_i + DW'(1);
        end else if (dec_i) begin
            next_o = at_zero ? MAX_V : value_i - DW'(1);
        end
    end

endmodule

// File: rtl/bcd_updown_counter_n.sv
// rtl/bcd_updown_counter_n.sv - multi-digit modulo-N up/down counter with wrap/saturate and terminal pulse
module bcd_updown_counter_n
    import stopwatch_pkg::*;
#(
    parameter int          DIGITS = 4,
    parameter int unsigned MOD    = BCD_MOD,
    parameter int          DW     = DIGIT_W
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 CLR,
    input  logic                 LOAD,
    input  logic [DIGITS*DW-1:0] LOAD_VAL,
    input  logic                 COUNT,
    input  logic                 MODE,
    input  logic                 WRAP,
    output logic [DIGITS*DW-1:0] Q,
    output logic                 TRG,
    output logic                 AT_MAX,
    output logic                 AT_ZERO
);

    localparam logic [DW-1:0] MAX_V = DW'(MOD - 1);

    logic [DIGITS*DW-1:0] q_q;
    logic [DIGITS*DW-1:0] q_d;
    logic                 trg_q;
    logic                 trg_d;

    logic [DIGITS*DW-1:0] cnt_next;
    logic [DIGITS*DW-1:0] load_clamped;
    logic [DIGITS:0]      inc_c;
    logic [DIGITS:0]      dec_c;
    logic [DIGITS-1:0]    digit_max;
    logic [DIGITS-1:0]    digit_zero;
    logic                 terminal;

    assign inc_c[0] = COUNT & MODE;
    assign dec_c[0] = COUNT & ~MODE;

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        bcd_digit_cell #(
            .MOD (MOD),
            .DW  (DW)
        ) u_cell (
            .value_i  (q_q[i*DW +: DW]),
            .inc_i    (inc_c[i]),
            .dec_i    (dec_c[i]),
            .next_o   (cnt_next[i*DW +: DW]),
            .carry_o  (inc_c[i+1]),
            .borrow_o (dec_c[i+1])
        );

        assign load_clamped[i*DW +: DW] = clamp_digit(LOAD_VAL[i*DW +: DW], MOD);
        assign digit_max[i]             = (q_q[i*DW +: DW] == MAX_V);
        assign digit_zero[i]            = (q_q[i*DW +: DW] == '0);
    end

    // A carry or borrow leaving the top digit is exactly a terminal event.
    assign terminal = inc_c[DIGITS] | dec_c[DIGITS];

    assign AT_MAX  = &digit_max;
    assign AT_ZERO = &digit_zero;
    assign Q       = q_q;
    assign TRG     = trg_q;

    // Priority mux: clear, then load, then count (wrap or hold at terminal), else hold.
    always_comb begin
        q_d   = q_q;
        trg_d = 1'b0;
        if (CLR) begin
            q_d = '0;
        end else if (LOAD) begin
            q_d = load_clamped;
        end else if (COUNT) begin
            trg_d = terminal;
            if (!terminal || WRAP) begin
                q_d = cnt_next;
            end
        end
    end

    // Digit and terminal-pulse registers with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            q_q   <= '0;
            trg_q <= 1'b0;
        end else begin
            q_q   <= q_d;
            trg_q <= trg_d;
        end
    end

endmodule

// File: tb/tb_bcd_updown_counter_n.sv
// tb/tb_bcd_updown_counter_n.sv - directed self-checking bench for bcd_updown_counter_n
module tb_bcd_updown_counter_n;

    logic clk;
    logic rst_n;
    logic clr;
    logic load;
    logic count;
    logic mode;
    logic wrap;

    logic [7:0]  lv2;
    logic [7:0]  q2;
    logic        trg2, amax2, azero2;

    logic [11:0] lv3;
    logic [11:0] q3;
    logic        trg3, amax3, azero3;

    logic [3:0]  lv1;
    logic [3:0]  q1;
    logic        trg1, amax1, azero1;

    int checks;
    int failures;

    bcd_updown_counter_n #(.DIGITS(2), .MOD(10), .DW(4)) u_dut2 (
        .CLK(clk), .RST_N(rst_n), .CLR(clr), .LOAD(load), .LOAD_VAL(lv2),
        .COUNT(count), .MODE(mode), .WRAP(wrap),
        .Q(q2), .TRG(trg2), .AT_MAX(amax2), .AT_ZERO(azero2)
    );

    bcd_updown_counter_n #(.DIGITS(3), .MOD(6), .DW(4)) u_dut3 (
        .CLK(clk), .RST_N(rst_n), .CLR(clr), .LOAD(load), .LOAD_VAL(lv3),
        .COUNT(count), .MODE(mode), .WRAP(wrap),
        .Q(q3), .TRG(trg3), .AT_MAX(amax3), .AT_ZERO(azero3)
    );

    bcd_updown_counter_n #(.DIGITS(1), .MOD(16), .DW(4)) u_dut1 (
        .CLK(clk), .RST_N(rst_n), .CLR(clr), .LOAD(load), .LOAD_VAL(lv1),
        .COUNT(count), .MODE(mode), .WRAP(wrap),
        .Q(q1), .TRG(trg1), .AT_MAX(amax1), .AT_ZERO(azero1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        clr   = 1'b0;
        load  = 1'b0;
        count = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; clr = 1'b0; load = 1'b1; count = 1'b1; mode = 1'b1; wrap = 1'b1;
        lv2 = 8'h37; lv3 = 12'h123; lv1 = 4'h7;
        step();
        step();
        checks++;
        if (q2 !== 8'h00) begin failures++; $display("FAIL reset_q got=%h exp=00", q2); end
        checks++;
        if (trg2 !== 1'b0) begin failures++; $display("FAIL reset_trg got=%b exp=0", trg2); end
        checks++;
        if (azero2 !== 1'b1 || amax2 !== 1'b0) begin
            failures++; $display("FAIL reset_flags zero=%b max=%b exp zero=1 max=0", azero2, amax2);
        end
        rst_n = 1'b1; load = 1'b0;
        step();
        checks++;
        if (q2 !== 8'h01 || trg2 !== 1'b0) begin
            failures++; $display("FAIL reset_release q=%h trg=%b exp q=01 trg=0", q2, trg2);
        end
        idle();
    endtask

    task automatic test_up_wrap();
        logic [7:0] exp_q [3];
        logic       exp_t [3];
        exp_q[0] = 8'h99; exp_t[0] = 1'b0;
        exp_q[1] = 8'h00; exp_t[1] = 1'b1;
        exp_q[2] = 8'h01; exp_t[2] = 1'b0;
        idle(); load = 1'b1; lv2 = 8'h98;
        step();
        checks++;
        if (q2 !== 8'h98 || trg2 !== 1'b0) begin
            failures++; $display("FAIL up_load q=%h trg=%b exp q=98 trg=0", q2, trg2);
        end
        load = 1'b0; count = 1'b1; mode = 1'b1; wrap = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (q2 !== exp_q[i] || trg2 !== exp_t[i]) begin
                failures++;
                $display("FAIL up_wrap[%0d] q=%h trg=%b exp q=%h trg=%b", i, q2, trg2, exp_q[i], exp_t[i]);
            end
            if (i == 0) begin
                checks++;
                if (amax2 !== 1'b1) begin failures++; $display("FAIL up_at_max got=%b exp=1", amax2); end
            end
        end
        idle();
    endtask

    task automatic test_down_wrap();
        logic [7:0] eq;
        logic       et;
        idle(); load = 1'b1; lv2 = 8'h10;
        step();
        load = 1'b0; count = 1'b1; mode = 1'b0; wrap = 1'b1;
        for (int i = 0; i < 11; i++) begin
            step();
            if (i < 10) begin
                eq = {4'd0, 4'(9 - i)};
                et = 1'b0;
            end else begin
                eq = 8'h99;
                et = 1'b1;
            end
            checks++;
            if (q2 !== eq || trg2 !== et) begin
                failures++;
                $display("FAIL down_wrap[%0d] q=%h trg=%b exp q=%h trg=%b", i, q2, trg2, eq, et);
            end
        end
        idle();
    endtask

    task automatic test_saturate();
        idle(); load = 1'b1; lv2 = 8'h99;
        step();
        load = 1'b0; count = 1'b1; mode = 1'b1; wrap = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (q2 !== 8'h99 || trg2 !== 1'b1) begin
                failures++; $display("FAIL sat_up[%0d] q=%h trg=%b exp q=99 trg=1", i, q2, trg2);
            end
        end
        count = 1'b0;
        step();
        checks++;
        if (q2 !== 8'h99 || trg2 !== 1'b0) begin
            failures++; $display("FAIL sat_idle q=%h trg=%b exp q=99 trg=0", q2, trg2);
        end
        load = 1'b1; lv2 = 8'h00;
        step();
        load = 1'b0; count = 1'b1; mode = 1'b0;
        step();
        checks++;
        if (q2 !== 8'h00 || trg2 !== 1'b1) begin
            failures++; $display("FAIL sat_down q=%h trg=%b exp q=00 trg=1", q2, trg2);
        end
        idle();
    endtask

    task automatic test_load_priority();
        idle(); load = 1'b1; lv2 = 8'hFA;
        step();
        checks++;
        if (q2 !== 8'h99) begin failures++; $display("FAIL clamp_fa q=%h exp=99", q2); end
        lv2 = 8'h5C;
        step();
        checks++;
        if (q2 !== 8'h59) begin failures++; $display("FAIL clamp_5c q=%h exp=59", q2); end
        lv2 = 8'h99; count = 1'b1; mode = 1'b1; wrap = 1'b1;
        step();
        checks++;
        if (q2 !== 8'h99 || trg2 !== 1'b0) begin
            failures++; $display("FAIL load_no_trg q=%h trg=%b exp q=99 trg=0", q2, trg2);
        end
        lv2 = 8'h42;
        step();
        checks++;
        if (q2 !== 8'h42 || trg2 !== 1'b0) begin
            failures++; $display("FAIL load_vs_count q=%h trg=%b exp q=42 trg=0", q2, trg2);
        end
        clr = 1'b1; lv2 = 8'h77;
        step();
        checks++;
        if (q2 !== 8'h00 || trg2 !== 1'b0) begin
            failures++; $display("FAIL clr_vs_load q=%h trg=%b exp q=00 trg=0", q2, trg2);
        end
        idle();
    endtask

    task automatic test_back_to_back();
        idle(); clr = 1'b1;
        step();
        clr = 1'b0; count = 1'b1; mode = 1'b1; wrap = 1'b1;
        step();
        step();
        checks++;
        if (q2 !== 8'h02) begin failures++; $display("FAIL b2b_up q=%h exp=02", q2); end
        mode = 1'b0;
        step();
        checks++;
        if (q2 !== 8'h01) begin failures++; $display("FAIL b2b_dir q=%h exp=01", q2); end
        mode = 1'b1;
        for (int i = 0; i < 9; i++) step();
        checks++;
        if (q2 !== 8'h10 || trg2 !== 1'b0) begin
            failures++; $display("FAIL b2b_carry q=%h trg=%b exp q=10 trg=0", q2, trg2);
        end
        idle();
    endtask

    task automatic test_param_sweep();
        idle(); load = 1'b1; lv3 = 12'h9F6; lv1 = 4'hF;
        step();
        checks++;
        if (q3 !== 12'h555 || amax3 !== 1'b1) begin
            failures++; $display("FAIL sweep_clamp3 q=%h max=%b exp q=555 max=1", q3, amax3);
        end
        checks++;
        if (q1 !== 4'hF || amax1 !== 1'b1) begin
            failures++; $display("FAIL sweep_load1 q=%h max=%b exp q=f max=1", q1, amax1);
        end
        load = 1'b0; count = 1'b1; mode = 1'b1; wrap = 1'b1;
        step();
        checks++;
        if (q3 !== 12'h000 || trg3 !== 1'b1) begin
            failures++; $display("FAIL sweep_wrap3 q=%h trg=%b exp q=000 trg=1", q3, trg3);
        end
        checks++;
        if (q1 !== 4'h0 || trg1 !== 1'b1) begin
            failures++; $display("FAIL sweep_wrap1 q=%h trg=%b exp q=0 trg=1", q1, trg1);
        end
        step();
        checks++;
        if (q3 !== 12'h001 || trg3 !== 1'b0 || q1 !== 4'h1 || trg1 !== 1'b0) begin
            failures++;
            $display("FAIL sweep_next q3=%h trg3=%b q1=%h trg1=%b exp 001 0 1 0", q3, trg3, q1, trg1);
        end
        mode = 1'b0;
        step();
        step();
        checks++;
        if (q3 !== 12'h555 || trg3 !== 1'b1) begin
            failures++; $display("FAIL sweep_down3 q=%h trg=%b exp q=555 trg=1", q3, trg3);
        end
        idle();
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst_n = 1'b0; clr = 1'b0; load = 1'b0; count = 1'b0; mode = 1'b1; wrap = 1'b1;
        lv2 = '0; lv3 = '0; lv1 = '0;
        test_reset();
        test_up_wrap();
        test_down_wrap();
        test_saturate();
        test_load_priority();
        test_back_to_back();
        test_param_sweep();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bcd_updown_counter_n.md
# bcd_updown_counter_n

Parametrised multi-digit modulo-N up/down counter for the stopwatch datapath. It is the generalised successor of the single-digit 0–9 counter: it adds a configurable digit count and modulus, an internal carry/borrow cascade, and a selectable wrap or saturate policy at the terminal counts. It also adds synchronous clear and load-value clamping, and produces a registered terminal-count pulse. Its packed digit bus drives the seven-segment display decoders directly.

## Interface
- DIGITS, 4: number of cascaded digits (1–8).
- MOD, 10: modulus of every digit (2–16). Each digit counts 0..MOD-1.
- DW, 4: digit width. Set to stopwatch_pkg::DIGIT_W and not overridden independently. Must satisfy 2^DW ≥ MOD.
- CLK  in  1  single clock. All state changes on its rising edge.
- RST_N  in  1  reset, synchronous, active-low.
- CLR  in  1  synchronous clear to all-zero.
- LOAD  in  1  synchronous parallel load from LOAD_VAL.
- LOAD_VAL  in  DIGITS*DW  load value. Digit i occupies bits [i*DW +: DW].
- COUNT  in  1  count enable.
- MODE  in  1  direction: 1 = up, 0 = down.
- WRAP  in  1  terminal policy: 1 = wrap around, 0 = saturate.
- Q  out  DIGITS*DW  registered digit bus, same packing as LOAD_VAL.
- TRG  out  1  registered one-cycle terminal-count pulse.
- AT_MAX  out  1  combinational: every digit == MOD-1.
- AT_ZERO  out  1  combinational: every digit == 0.

## Operation
- Per-edge priority: RST_N low > CLR > LOAD > COUNT > hold.
- Reset: Q = 0 and TRG = 0. CLR gives the same result, but only when RST_N is high.
- LOAD: each digit takes its LOAD_VAL digit. A digit value ≥ MOD is clamped to MOD-1. LOAD never asserts TRG.
- Up count (MODE=1, COUNT=1): digit 0 increments.
  - A digit at MOD-1 becomes 0 and carries into the next digit.
  - Carry ripples combinationally within the same edge. There is no per-digit latency.
- Down count (MODE=0, COUNT=1): digit 0 decrements.
  - A digit at 0 becomes MOD-1 and borrows from the next digit.
- Terminal event: counting up while AT_MAX, or counting down while AT_ZERO.
  - With WRAP=1: Q wraps to all-zero (up) or all-(MOD-1) (down).
  - With WRAP=0: Q holds.
  - In both cases TRG = 1 for the following cycle.
- Saturate hold: if COUNT stays high at a terminal value with WRAP=0, TRG pulses on every enabled edge. The downstream controller gates on it.
- MODE, WRAP and COUNT are sampled at each edge. A change takes effect on the next edge without glitching Q.
- COUNT=0: Q holds and TRG = 0.

## Timing
- Q and TRG update one CLK edge after the controlling inputs are sampled. Latency is 1 cycle.
- TRG is high for exactly one cycle per terminal event and coincides with the post-wrap Q value.
- AT_MAX and AT_ZERO are decoded from the current Q with zero latency. They are not registered.
- RST_N low mid-count: Q = 0 and TRG = 0 on that edge, regardless of CLR, LOAD or COUNT.
- LOAD and COUNT together: the load wins and this edge does not count.
- CLR and LOAD together: the clear wins.
- DIGITS=1 behaves as a single modulo-MOD digit, with TRG on each wrap.

## Structure
- stopwatch_pkg holds:
  - DIGIT_W = 4;
  - BCD_MOD = 10;
  - the typedef digit_t = logic [DIGIT_W-1:0];
  - the function clamp_digit.
- Sub-module bcd_digit_cell: one combinational digit.
  - Inputs: value, inc, dec, MOD.
  - Outputs: next value, carry_out, borrow_out.
  - Instantiated DIGITS times with a generate loop.
- The top level holds the Q and TRG registers, the priority mux, the terminal decode and the WRAP/saturate selection.

## Test plan
All scenarios use DIGITS=2, MOD=10 unless stated.
- Reset: RST_N=0 for 2 edges with COUNT=1, LOAD=1, LOAD_VAL=0x37 -> Q=0x00, TRG=0. After release with COUNT=1, MODE=1 -> Q=0x01 after one edge.
- Up wrap: load 0x98, then COUNT=1, MODE=1, WRAP=1 for 3 edges -> Q = 0x99, 0x00, 0x01. TRG=1 only in the cycle Q=0x00.
- Down borrow and wrap: load 0x10, MODE=0, WRAP=1 -> Q = 0x09 … 0x00, 0x99. TRG=1 only in the cycle Q=0x99.
- Saturate: load 0x99, MODE=1, WRAP=0, COUNT=1 for 3 edges -> Q stays 0x99 and TRG=1 in each of the 3 cycles. Then COUNT=0 -> TRG=0.
- Load clamp and priority:
  - LOAD_VAL=0xFA -> Q=0x99.
  - LOAD together with COUNT -> Q=LOAD_VAL, no increment.
  - CLR together with LOAD -> Q=0x00.
- Parameter sweep: DIGITS=3, MOD=6, start 0x555, count up -> Q=0x000 and TRG=1. DIGITS=1, MOD=16 -> digit wraps 0xF→0x0 with TRG=1.
